mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/rk16_mem_pkg.sv | 41 ++++
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/rr_arb2.sv | 33 +++
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/rk16_mem_pkg.sv
// Shared types and constants for the rk16 memory arbiter: lock states,
// access owners, request payload and the read-only address window.
package rk16_mem_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  localparam logic [ADDR_W-1:0] RESERVED_TOP = 16'h0002;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    DRAIN    = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic              valid;
    owner_t            owner;
    logic              load;
    logic              mem_we;
    logic              err;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } stage1_t;

  function automatic logic is_reserved(input logic [ADDR_W-1:0] addr);
    return addr <= RESERVED_TOP;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU/debug requesters, the arbiter and the memory.
interface mem_arbiter_if;
  import rk16_mem_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_lock;
  logic              dbg_locked;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_st_data;
  logic              mem_we;
  logic [DATA_W-1:0] mem_ld_data;
  logic              wr_err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_locked,
    output mem_addr, mem_st_data, mem_we, wr_err,
    input  mem_ld_data
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_locked,
    input  mem_addr, mem_st_data, mem_we, wr_err,
    output mem_ld_data
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, priority pointer
// moves to the other port after every grant.
module rr_arb2 #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio_q;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || !prio_q)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= RR_INIT;
    end else if (gnt[0]) begin
      prio_q <= 1'b1;
    end else if (gnt[1]) begin
      prio_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-stage CPU/debug memory arbiter with round-robin grant, read-only
// low-address window and a debug exclusive-lock FSM.
module mem_arbiter
  import rk16_mem_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  lock_state_t       state_q, state_d;
  stage1_t           s1_q;
  logic              cpu_rv_q, dbg_rv_q;
  logic [DATA_W-1:0] ld_q;

  logic [1:0] arb_req, arb_gnt;
  logic       accept;
  owner_t     sel_owner;
  req_t       cpu_p, dbg_p, sel_p;
  logic       sel_res;
  logic       cpu_in_s1;

  // CPU is masked while the lock FSM is draining or locked; nothing is granted in reset.
  assign arb_req = {rst_n & bus.dbg_req, rst_n & bus.cpu_req & (state_q == UNLOCKED)};

  rr_arb2 #(.RR_INIT(RR_INIT)) u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (arb_req),
    .gnt   (arb_gnt)
  );

  assign cpu_p     = {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata};
  assign dbg_p     = {bus.dbg_we, bus.dbg_addr, bus.dbg_wdata};
  assign accept    = |arb_gnt;
  assign sel_owner = arb_gnt[1] ? OWN_DBG : OWN_CPU;
  assign sel_p     = arb_gnt[1] ? dbg_p : cpu_p;
  assign sel_res   = is_reserved(sel_p.addr);
  assign cpu_in_s1 = s1_q.valid && (s1_q.owner == OWN_CPU);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= UNLOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      UNLOCKED: if (bus.dbg_lock) state_d = DRAIN;
      DRAIN: begin
        if (!bus.dbg_lock)  state_d = UNLOCKED;
        else if (!cpu_in_s1) state_d = LOCKED;
      end
      LOCKED:   if (!bus.dbg_lock) state_d = UNLOCKED;
      default:  state_d = UNLOCKED;
    endcase
  end

  // Stage 1: accepted access drives memory; reserved stores become wr_err instead of mem_we.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else begin
      s1_q.valid  <= accept;
      s1_q.owner  <= sel_owner;
      s1_q.load   <= accept & ~sel_p.we;
      s1_q.mem_we <= accept & sel_p.we & ~sel_res;
      s1_q.err    <= accept & sel_p.we & sel_res;
      s1_q.addr   <= accept ? sel_p.addr  : '0;
      s1_q.wdata  <= accept ? sel_p.wdata : '0;
    end
  end

  // Stage 2: load data is captured for every access, but only loads raise rvalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_rv_q <= 1'b0;
      dbg_rv_q <= 1'b0;
      ld_q     <= '0;
    end else begin
      cpu_rv_q <= s1_q.load & (s1_q.owner == OWN_CPU);
      dbg_rv_q <= s1_q.load & (s1_q.owner == OWN_DBG);
      if (s1_q.valid) ld_q <= bus.mem_ld_data;
    end
  end

  // Outputs are forced low for the whole time rst_n is held, including the first reset cycle.
  assign bus.cpu_gnt     = arb_gnt[0];
  assign bus.dbg_gnt     = arb_gnt[1];
  assign bus.cpu_rvalid  = rst_n & cpu_rv_q;
  assign bus.dbg_rvalid  = rst_n & dbg_rv_q;
  assign bus.cpu_rdata   = (rst_n & cpu_rv_q) ? ld_q : '0;
  assign bus.dbg_rdata   = (rst_n & dbg_rv_q) ? ld_q : '0;
  assign bus.dbg_locked  = rst_n & (state_q == LOCKED);
  assign bus.mem_addr    = rst_n ? s1_q.addr  : '0;
  assign bus.mem_st_data = rst_n ? s1_q.wdata : '0;
  assign bus.mem_we      = rst_n & s1_q.mem_we;
  assign bus.wr_err      = rst_n & s1_q.err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: loads, round-robin, reserved stores,
// debug lock, reset abort and back-to-back debug loads.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.RR_INIT(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_model(input logic [15:0] a);
    return (a == 16'h0100) ? 16'hBEEF : (a ^ 16'hA5A5);
  endfunction

  assign bus.mem_ld_data = mem_model(bus.mem_addr);

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
  endtask

  task automatic cpu_drive(input logic we, input logic [15:0] a, input logic [15:0] d);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic dbg_drive(input logic we, input logic [15:0] a, input logic [15:0] d);
    bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cgnt"},   16'(bus.cpu_gnt), 16'h0);
    check({tag, "_dgnt"},   16'(bus.dbg_gnt), 16'h0);
    check({tag, "_crv"},    16'(bus.cpu_rvalid), 16'h0);
    check({tag, "_drv"},    16'(bus.dbg_rvalid), 16'h0);
    check({tag, "_crd"},    bus.cpu_rdata, 16'h0);
    check({tag, "_drd"},    bus.dbg_rdata, 16'h0);
    check({tag, "_maddr"},  bus.mem_addr, 16'h0);
    check({tag, "_mst"},    bus.mem_st_data, 16'h0);
    check({tag, "_mwe"},    16'(bus.mem_we), 16'h0);
    check({tag, "_werr"},   16'(bus.wr_err), 16'h0);
    check({tag, "_locked"}, 16'(bus.dbg_locked), 16'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.dbg_lock = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    bus.dbg_lock = 1'b0;
    next_cycle();
    next_cycle();
    // Requests during reset must not be granted.
    cpu_drive(1'b1, 16'h0200, 16'h1111);
    dbg_drive(1'b0, 16'h0300, 16'h0);
    #2 check_all_zero("rst");
    next_cycle();
    clear_inputs();
    rst_n = 1'b1;

    // CPU load from 0x0100.
    cpu_drive(1'b0, 16'h0100, 16'h0);
    #2 check("ld_gnt", 16'(bus.cpu_gnt), 16'h1);
    check("ld_dgnt", 16'(bus.dbg_gnt), 16'h0);
    next_cycle(); clear_inputs();
    #2 check("ld_maddr", bus.mem_addr, 16'h0100);
    check("ld_mwe", 16'(bus.mem_we), 16'h0);
    check("ld_rv_n1", 16'(bus.cpu_rvalid), 16'h0);
    next_cycle();
    #2 check("ld_rv", 16'(bus.cpu_rvalid), 16'h1);
    check("ld_rd", bus.cpu_rdata, 16'hBEEF);
    check("ld_drv", 16'(bus.dbg_rvalid), 16'h0);
    next_cycle();
    #2 check("ld_rv_off", 16'(bus.cpu_rvalid), 16'h0);
    check("ld_rd_off", bus.cpu_rdata, 16'h0);
    check("ld_maddr_idle", bus.mem_addr, 16'h0);

    // Round-robin with both ports requesting right out of reset.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        cpu_drive(1'b0, 16'h0020, 16'h0);
        dbg_drive(1'b0, 16'h0030, 16'h0);
      end else begin
        clear_inputs();
      end
      #2;
      check($sformatf("rr_cgnt%0d", i), 16'(bus.cpu_gnt), 16'((i < 4) && (i % 2 == 0)));
      check($sformatf("rr_dgnt%0d", i), 16'(bus.dbg_gnt), 16'((i < 4) && (i % 2 == 1)));
      if (i >= 2) begin
        check($sformatf("rr_crv%0d", i), 16'(bus.cpu_rvalid), 16'(i % 2 == 0));
        check($sformatf("rr_drv%0d", i), 16'(bus.dbg_rvalid), 16'(i % 2 == 1));
        if (i % 2 == 0) check($sformatf("rr_crd%0d", i), bus.cpu_rdata, mem_model(16'h0020));
        else            check($sformatf("rr_drd%0d", i), bus.dbg_rdata, mem_model(16'h0030));
      end
      next_cycle();
    end

    // Store to the read-only window is dropped with wr_err.
    cpu_drive(1'b1, 16'h0001, 16'h1234);
    #2 check("ro_gnt", 16'(bus.cpu_gnt), 16'h1);
    next_cycle(); clear_inputs();
    #2 check("ro_mwe", 16'(bus.mem_we), 16'h0);
    check("ro_werr", 16'(bus.wr_err), 16'h1);
    check("ro_maddr", bus.mem_addr, 16'h0001);
    next_cycle();
    cpu_drive(1'b0, 16'h0001, 16'h0);
    #2 check("ro_werr_off", 16'(bus.wr_err), 16'h0);
    check("ro_st_rv", 16'(bus.cpu_rvalid), 16'h0);
    check("ro_ld_gnt", 16'(bus.cpu_gnt), 16'h1);
    next_cycle(); clear_inputs();
    next_cycle();
    #2 check("ro_ld_rv", 16'(bus.cpu_rvalid), 16'h1);
    check("ro_ld_rd", bus.cpu_rdata, 16'hA5A4);

    // Normal debug store reaches memory.
    next_cycle();
    dbg_drive(1'b1, 16'h0200, 16'h5555);
    #2 check("st_gnt", 16'(bus.dbg_gnt), 16'h1);
    next_cycle(); clear_inputs();
    #2 check("st_mwe", 16'(bus.mem_we), 16'h1);
    check("st_maddr", bus.mem_addr, 16'h0200);
    check("st_data", bus.mem_st_data, 16'h5555);
    check("st_werr", 16'(bus.wr_err), 16'h0);
    next_cycle();
    #2 check("st_drv", 16'(bus.dbg_rvalid), 16'h0);
    check("st_mwe_off", 16'(bus.mem_we), 16'h0);

    // Lock raised with a CPU load in stage 1: one drain cycle, then locked.
    next_cycle();
    cpu_drive(1'b0, 16'h0040, 16'h0);
    #2 check("lk_gnt", 16'(bus.cpu_gnt), 16'h1);
    next_cycle(); clear_inputs(); bus.dbg_lock = 1'b1;
    #2 check("lk_s1addr", bus.mem_addr, 16'h0040);
    check("lk_locked0", 16'(bus.dbg_locked), 16'h0);
    next_cycle(); cpu_drive(1'b0, 16'h0050, 16'h0);
    #2 check("lk_drain_gnt", 16'(bus.cpu_gnt), 16'h0);
    check("lk_drain_locked", 16'(bus.dbg_locked), 16'h0);
    check("lk_crv", 16'(bus.cpu_rvalid), 16'h1);
    check("lk_crd", bus.cpu_rdata, mem_model(16'h0040));
    next_cycle(); dbg_drive(1'b0, 16'h0011, 16'h0);
    #2 check("lk_locked", 16'(bus.dbg_locked), 16'h1);
    check("lk_cgnt", 16'(bus.cpu_gnt), 16'h0);
    check("lk_dgnt", 16'(bus.dbg_gnt), 16'h1);
    next_cycle(); bus.dbg_req = 1'b0; bus.dbg_lock = 1'b0;
    #2 check("lk_cgnt2", 16'(bus.cpu_gnt), 16'h0);
    check("lk_maddr", bus.mem_addr, 16'h0011);
    next_cycle();
    #2 check("unlk_locked", 16'(bus.dbg_locked), 16'h0);
    check("unlk_cgnt", 16'(bus.cpu_gnt), 16'h1);
    check("unlk_drv", 16'(bus.dbg_rvalid), 16'h1);
    next_cycle(); clear_inputs();
    next_cycle();

    // Lock rise coinciding with a lone CPU request: CPU still granted.
    cpu_drive(1'b0, 16'h0060, 16'h0);
    bus.dbg_lock = 1'b1;
    #2 check("co_gnt", 16'(bus.cpu_gnt), 16'h1);
    next_cycle();
    #2 check("co_drain_gnt", 16'(bus.cpu_gnt), 16'h0);
    next_cycle();
    #2 check("co_drain2_locked", 16'(bus.dbg_locked), 16'h0);
    next_cycle();
    #2 check("co_locked", 16'(bus.dbg_locked), 16'h1);
    check("co_locked_gnt", 16'(bus.cpu_gnt), 16'h0);
    next_cycle(); clear_inputs(); bus.dbg_lock = 1'b0;
    next_cycle();

    // Reset asserted the cycle after a CPU store grant.
    cpu_drive(1'b1, 16'h0300, 16'h7777);
    #2 check("ra_gnt", 16'(bus.cpu_gnt), 16'h1);
    next_cycle(); rst_n = 1'b0;
    cpu_drive(1'b0, 16'h0301, 16'h0);
    dbg_drive(1'b0, 16'h0302, 16'h0);
    #2 check_all_zero("ra1");
    next_cycle();
    #2 check_all_zero("ra2");
    next_cycle(); clear_inputs(); rst_n = 1'b1;
    #2 check("ra_mwe", 16'(bus.mem_we), 16'h0);
    check("ra_crv", 16'(bus.cpu_rvalid), 16'h0);
    next_cycle();
    #2 check("ra_crv2", 16'(bus.cpu_rvalid), 16'h0);
    check("ra_mwe2", 16'(bus.mem_we), 16'h0);

    // Eight back-to-back debug loads.
    next_cycle();
    for (int i = 0; i < 11; i++) begin
      if (i < 8) dbg_drive(1'b0, 16'(16'h0010 + i), 16'h0);
      else       clear_inputs();
      #2;
      check($sformatf("b2b_gnt%0d", i), 16'(bus.dbg_gnt), 16'(i < 8));
      check($sformatf("b2b_rv%0d", i), 16'(bus.dbg_rvalid), 16'((i >= 2) && (i < 10)));
      if ((i >= 2) && (i < 10))
        check($sformatf("b2b_rd%0d", i), bus.dbg_rdata, mem_model(16'(16'h0010 + i - 2)));
      check($sformatf("b2b_crv%0d", i), 16'(bus.cpu_rvalid), 16'h0);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
